// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
// master: operand source and result sink; slave: the adder.
interface pipelined_adder_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder/subtractor, one SEG-bit slice per stage.
// Ports: clk, rst (sync, active-high), io (pipelined_adder_if.slave):
//   in_valid/in_ready/a/b/cin/sub in, out_valid/out_ready/sum/cout/ovf out.
// Optional macro PIPELINED_ADDER_SAT_EN: saturate sum on signed overflow.
module pipelined_adder #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    pipelined_adder_if.slave     io
);
    localparam int STAGES = WIDTH / SEG;
    localparam int L      = STAGES - 1;

    // Slot 0 holds captured operands (b already inverted for subtract,
    // carry already the effective carry-in). Stage k reads slot k and
    // writes slot k+1; slot STAGES is the output register.
    logic [STAGES:0]  vld_q, vld_d;
    logic [STAGES:0]  cy_q, cy_d;
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] a_d [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] b_d [STAGES];
    logic [WIDTH-1:0] s_q [STAGES+1];
    logic [WIDTH-1:0] s_d [STAGES+1];
    logic             ovf_q, ovf_d;

    logic             adv;
    logic [SEG:0]     part [STAGES];
    logic [WIDTH-1:0] wrap_sum;
    logic [WIDTH-1:0] fin_sum;
    logic             ovf_c;

    function automatic logic [SEG:0] seg_add(
        input logic [SEG-1:0] x,
        input logic [SEG-1:0] y,
        input logic           c
    );
        return {1'b0, x} + {1'b0, y} + (SEG+1)'(c);
    endfunction

    // Whole pipe moves together; a stall freezes every slot.
    assign adv = !vld_q[STAGES] || io.out_ready;

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            part[k] = seg_add(a_q[k][k*SEG +: SEG],
                              b_q[k][k*SEG +: SEG],
                              cy_q[k]);
        end
        wrap_sum = s_q[L];
        wrap_sum[L*SEG +: SEG] = part[L][SEG-1:0];
        ovf_c = (a_q[L][WIDTH-1] == b_q[L][WIDTH-1])
             && (wrap_sum[WIDTH-1] != a_q[L][WIDTH-1]);
    end

`ifdef PIPELINED_ADDER_SAT_EN
    always_comb begin
        fin_sum = wrap_sum;
        if (ovf_c) begin
            if (a_q[L][WIDTH-1]) begin
                fin_sum = {1'b1, {(WIDTH-1){1'b0}}};
            end else begin
                fin_sum = {1'b0, {(WIDTH-1){1'b1}}};
            end
        end
    end
`else
    always_comb begin
        fin_sum = wrap_sum;
    end
`endif

    always_comb begin
        vld_d = vld_q;
        cy_d  = cy_q;
        a_d   = a_q;
        b_d   = b_q;
        s_d   = s_q;
        ovf_d = ovf_q;
        if (adv) begin
            // in_ready == adv, so in_valid alone marks an accept;
            // otherwise a bubble enters.
            vld_d[0] = io.in_valid;
            a_d[0]   = io.a;
            b_d[0]   = io.sub ? ~io.b : io.b;
            cy_d[0]  = io.sub ? ~io.cin : io.cin;
            s_d[0]   = '0;
            for (int k = 0; k < L; k++) begin
                vld_d[k+1] = vld_q[k];
                cy_d[k+1]  = part[k][SEG];
                a_d[k+1]   = a_q[k];
                b_d[k+1]   = b_q[k];
                s_d[k+1]   = s_q[k];
                s_d[k+1][k*SEG +: SEG] = part[k][SEG-1:0];
            end
            vld_d[STAGES] = vld_q[L];
            cy_d[STAGES]  = part[L][SEG];
            s_d[STAGES]   = fin_sum;
            ovf_d         = ovf_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            cy_q  <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
            for (int k = 0; k <= STAGES; k++) begin
                s_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            cy_q  <= cy_d;
            ovf_q <= ovf_d;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
            end
            for (int k = 0; k <= STAGES; k++) begin
                s_q[k] <= s_d[k];
            end
        end
    end

    assign io.in_ready  = adv;
    assign io.out_valid = vld_q[STAGES];
    assign io.sum       = s_q[STAGES];
    assign io.cout      = cy_q[STAGES];
    assign io.ovf       = ovf_q;
endmodule
